// File: rtl/jtframe_pocket_dwnld.sv
// Pocket bridge download sequencer: buffers 32-bit bridge words and replays
// them as four byte-wide ioctl writes, each waiting for the loader's prog_rdy.
module jtframe_pocket_dwnld #(
  parameter int DEPTH = 2,
  parameter int AW    = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [31:0]   wr_data,
  input  logic [31:0]   wr_addr,
  input  logic          slot_done,
  input  logic          prog_rdy,
  output logic [AW-1:0] ioctl_addr,
  output logic [7:0]    ioctl_dout,
  output logic          ioctl_wr,
  output logic          downloading,
  output logic          overflow,
  output logic [DEPTH:0] fifo_lvl
);

  localparam int N  = 1 << DEPTH;
  localparam int EW = AW - 2 + 32;

  typedef enum logic { ST_IDLE, ST_WAIT } state_t;

  logic [EW-1:0]    r_mem [N];
  logic [DEPTH-1:0] r_wptr;
  logic [DEPTH-1:0] r_rptr;
  state_t           r_state;
  logic [1:0]       r_cnt;
  logic [31:0]      r_shift;
  logic             r_pend;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_done;
  logic [EW-1:0] w_head;
  logic          w_unused_addr;

  assign w_full  = (fifo_lvl == (DEPTH+1)'(N));
  assign w_empty = (fifo_lvl == '0);
  assign w_push  = wr & ~w_full;
  assign w_pop   = (r_state == ST_IDLE) & ~w_empty;
  assign w_head  = r_mem[r_rptr];
  // A word arriving in the finishing cycle keeps the download alive
  assign w_done  = r_pend & w_empty & (r_state == ST_IDLE) & ~wr;
  assign w_unused_addr = ^{wr_addr[31:AW], wr_addr[1:0]};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {wr_addr[AW-1:2], wr_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      fifo_lvl    <= '0;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_pend      <= 1'b0;
      ioctl_addr  <= '0;
      ioctl_dout  <= '0;
      ioctl_wr    <= 1'b0;
      downloading <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      fifo_lvl <= fifo_lvl + 1'b1;
      else if (!w_push && w_pop) fifo_lvl <= fifo_lvl - 1'b1;

      if (wr && w_full)                 overflow <= 1'b1;
      else if (w_push && !downloading)  overflow <= 1'b0;

      if (w_push && !downloading) downloading <= 1'b1;
      if (w_done) begin
        downloading <= 1'b0;
        r_pend      <= 1'b0;
      end else if (slot_done && downloading) begin
        r_pend <= 1'b1;
      end

      ioctl_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            ioctl_addr <= {w_head[EW-1:32], 2'b00};
            ioctl_dout <= w_head[7:0];
            r_shift    <= w_head[31:0];
            ioctl_wr   <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // An acknowledge coinciding with the strobe cannot belong to it
          if (prog_rdy && !ioctl_wr) begin
            if (r_cnt == 2'd3) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt           <= r_cnt + 2'd1;
              ioctl_addr[1:0] <= ioctl_addr[1:0] + 2'd1;
              r_shift         <= r_shift >> 8;
              ioctl_dout      <= r_shift[15:8];
              ioctl_wr        <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Bench for jtframe_pocket_dwnld: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_jtframe_pocket_dwnld;

  localparam int DEPTH = 2;
  localparam int AW    = 25;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr;
  logic [31:0]   wr_data;
  logic [31:0]   wr_addr;
  logic          slot_done;
  logic          prog_rdy;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wr;
  logic          downloading;
  logic          overflow;
  logic [DEPTH:0] fifo_lvl;

  logic rdyAuto = 1'b0;
  logic rdyMan  = 1'b0;
  logic rdyEn   = 1'b0;
  assign prog_rdy = rdyAuto | rdyMan;

  int assertions = 0;
  int failures   = 0;

  jtframe_pocket_dwnld #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wr_data(wr_data), .wr_addr(wr_addr),
    .slot_done(slot_done), .prog_rdy(prog_rdy), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .downloading(downloading),
    .overflow(overflow), .fifo_lvl(fifo_lvl)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words queue up, each is replayed byte by byte
  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  ent_t          mq[$];
  ent_t          mEnt;
  bit            mValid = 0;
  bit            mBusy;
  int            mIdx;
  logic [31:0]   mWord;
  logic          eWr, eDl, eOvf, ePend;
  logic [AW-1:0] eAddr;
  logic [7:0]    eDout;
  logic [DEPTH:0] eLvl;
  int            sizeBefore;
  bit            prevWr, dlBefore, doneNow;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mBusy = 0; mIdx = 0; mWord = '0;
      eWr = 0; eDl = 0; eOvf = 0; ePend = 0; eAddr = '0; eDout = '0; eLvl = '0;
      mValid = 1;
    end else begin
      prevWr     = eWr;
      sizeBefore = mq.size();
      dlBefore   = eDl;
      doneNow    = ePend && sizeBefore == 0 && !mBusy && !wr;
      eWr = 0;
      if (!mBusy && sizeBefore > 0) begin
        mEnt  = mq.pop_front();
        mBusy = 1;
        mIdx  = 0;
        mWord = mEnt.d;
        eAddr = mEnt.a;
        eDout = mWord[7:0];
        eWr   = 1;
      end else if (mBusy && prog_rdy && !prevWr) begin
        if (mIdx == 3) begin
          mBusy = 0;
        end else begin
          mIdx  = mIdx + 1;
          eAddr = eAddr + 1;
          eDout = mWord[8*mIdx +: 8];
          eWr   = 1;
        end
      end
      if (wr) begin
        if (sizeBefore < (1 << DEPTH)) begin
          mEnt.a = {wr_addr[AW-1:2], 2'b00};
          mEnt.d = wr_data;
          mq.push_back(mEnt);
          if (!dlBefore) begin
            eDl  = 1;
            eOvf = 0;
          end
        end else begin
          eOvf = 1;
        end
      end
      if (doneNow) begin
        eDl = 0; ePend = 0;
      end else if (slot_done && dlBefore) begin
        ePend = 1;
      end
      eLvl = (DEPTH+1)'(mq.size());
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("cyc_ioctl_wr",    ioctl_wr,          eWr);
      checkOutput("cyc_ioctl_addr",  32'(ioctl_addr),   32'(eAddr));
      checkOutput("cyc_ioctl_dout",  ioctl_dout,        eDout);
      checkOutput("cyc_downloading", downloading,       eDl);
      checkOutput("cyc_overflow",    overflow,          eOvf);
      checkOutput("cyc_fifo_lvl",    fifo_lvl,          eLvl);
    end
  end

  // Log of every byte strobe seen on the ioctl side
  logic [31:0] logA[$];
  logic [7:0]  logD[$];
  always @(negedge clk) begin
    if (ioctl_wr) begin
      logA.push_back(32'(ioctl_addr));
      logD.push_back(ioctl_dout);
    end
  end

  // Loader emulation: acknowledge three cycles after each strobe when enabled
  int cd = 0;
  bit pendByte = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cd = 0; pendByte = 0; rdyAuto = 1'b0;
    end else begin
      rdyAuto = 1'b0;
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) rdyAuto = 1'b1;
      end
      if (ioctl_wr) pendByte = 1;
      if (rdyEn && pendByte && cd == 0 && !rdyAuto) begin
        cd = 3;
        pendByte = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic sd);
    wr = 1'b1; wr_addr = a; wr_data = d; slot_done = sd;
    step(1);
    wr = 1'b0; slot_done = 1'b0;
  endtask

  task automatic pulseDone();
    slot_done = 1'b1;
    step(1);
    slot_done = 1'b0;
  endtask

  task automatic waitPulses(input int target, input string name);
    int n = 0;
    while (logA.size() < target && n < 500) begin
      step(1);
      n++;
    end
    checkOutput(name, 32'(logA.size() >= target), 32'd1);
  endtask

  task automatic waitDlLow(input string name);
    int n = 0;
    while (downloading && n < 500) begin
      step(1);
      n++;
    end
    checkOutput(name, downloading, 1'b0);
  endtask

  int base;
  logic [7:0]  bytes1[4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
  logic [31:0] addr6[8]  = '{32'h0, 32'h1, 32'h2, 32'h3,
                             32'h2000, 32'h2001, 32'h2002, 32'h2003};
  logic [7:0]  bytes6[8] = '{8'h0D, 8'h0C, 8'h0B, 8'h0A,
                             8'h1D, 8'h1C, 8'h1B, 8'h1A};

  initial begin
    rst_n = 1'b0; wr = 1'b0; wr_addr = '0; wr_data = '0; slot_done = 1'b0;
    step(3);
    checkOutput("rst_ioctl_wr",    ioctl_wr,         0);
    checkOutput("rst_ioctl_addr",  32'(ioctl_addr),  0);
    checkOutput("rst_downloading", downloading,      0);
    checkOutput("rst_overflow",    overflow,         0);
    checkOutput("rst_fifo_lvl",    fifo_lvl,         0);
    rst_n = 1'b1;
    step(1);

    // Single word: latency, byte order, addresses
    rdyEn = 1'b1;
    base = logA.size();
    applyStimulus(32'h100, 32'hA1B2C3D4, 1'b0);
    checkOutput("t1_latency_c1", ioctl_wr, 0);
    step(1);
    checkOutput("t1_latency_c2", ioctl_wr, 1);
    checkOutput("t1_downloading", downloading, 1);
    waitPulses(base + 4, "t1_pulses");
    step(8);
    checkOutput("t1_count", logA.size(), base + 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1_addr", logA[base+i], 32'h100 + i);
      checkOutput("t1_byte", logD[base+i], bytes1[i]);
    end
    checkOutput("t1_dl_hold", downloading, 1);

    // Acknowledges during the strobe and while idle are ignored
    rdyEn = 1'b0;
    base = logA.size();
    applyStimulus(32'h200, 32'h11223344, 1'b0);
    step(1);
    rdyMan = 1'b1;
    step(1);
    rdyMan = 1'b0;
    step(3);
    checkOutput("t4_no_extra", logA.size(), base + 1);
    rdyEn = 1'b1;
    waitPulses(base + 4, "t4_pulses");
    step(8);
    checkOutput("t4_count", logA.size(), base + 4);
    checkOutput("t4_last_addr", logA[base+3], 32'h203);
    rdyMan = 1'b1;
    step(1);
    rdyMan = 1'b0;
    step(4);
    checkOutput("t4_idle_rdy", logA.size(), base + 4);

    // Five back-to-back words with the engine idle: all accepted
    rdyEn = 1'b0;
    base = logA.size();
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_addr = 32'h400 + 32'(16 * i);
      wr_data = 32'h10203040 + 32'(i) * 32'h01010101;
      step(1);
    end
    wr = 1'b0;
    checkOutput("t2a_lvl", fifo_lvl, 4);
    checkOutput("t2a_ovf", overflow, 0);
    checkOutput("t2a_popped", logA.size(), base + 1);
    rdyEn = 1'b1;
    waitPulses(base + 20, "t2a_pulses");
    step(8);
    checkOutput("t2a_count", logA.size(), base + 20);
    checkOutput("t2a_last_addr", logA[base+19], 32'h443);
    checkOutput("t2a_last_byte", logD[base+19], 8'h14);

    // Five back-to-back words with the engine stalled: fifth dropped
    rdyEn = 1'b0;
    base = logA.size();
    applyStimulus(32'h800, 32'hDEADBEEF, 1'b0);
    step(3);
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_addr = 32'h900 + 32'(16 * i);
      wr_data = 32'h10203040 + 32'(i) * 32'h01010101;
      step(1);
    end
    wr = 1'b0;
    checkOutput("t2b_lvl", fifo_lvl, 4);
    checkOutput("t2b_ovf", overflow, 1);
    checkOutput("t2b_popped", logA.size(), base + 1);
    rdyEn = 1'b1;
    waitPulses(base + 20, "t2b_pulses");
    step(8);
    checkOutput("t2b_count", logA.size(), base + 20);
    checkOutput("t2b_last_addr", logA[base+19], 32'h933);
    checkOutput("t2b_last_byte", logD[base+19], 8'h13);
    pulseDone();
    waitDlLow("t2b_dl_fall");
    checkOutput("t2b_ovf_sticky", overflow, 1);

    // Completion requested while words are still queued
    rdyEn = 1'b0;
    base = logA.size();
    applyStimulus(32'hC00, 32'hCAFEF00D, 1'b0);
    applyStimulus(32'hC04, 32'h01234567, 1'b0);
    checkOutput("t3_ovf_clear", overflow, 0);
    checkOutput("t3_lvl", fifo_lvl, 1);
    pulseDone();
    checkOutput("t3_dl_pending", downloading, 1);
    rdyEn = 1'b1;
    waitPulses(base + 8, "t3_pulses");
    for (int n = 0; n < 20 && !prog_rdy; n++) step(1);
    checkOutput("t3_last_ack", prog_rdy, 1);
    step(1);
    checkOutput("t3_dl_after_ack", downloading, 1);
    step(1);
    checkOutput("t3_dl_fell", downloading, 0);

    // Reset in the middle of a word
    base = logA.size();
    applyStimulus(32'hA00, 32'h55667788, 1'b0);
    waitPulses(base + 2, "t5_two_bytes");
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checkOutput("t5_rst_wr",   ioctl_wr,        0);
    checkOutput("t5_rst_addr", 32'(ioctl_addr), 0);
    checkOutput("t5_rst_dout", ioctl_dout,      0);
    checkOutput("t5_rst_dl",   downloading,     0);
    checkOutput("t5_rst_lvl",  fifo_lvl,        0);
    step(10);
    checkOutput("t5_no_more", logA.size(), base + 2);
    applyStimulus(32'hB00, 32'h99AABBCC, 1'b0);
    waitPulses(base + 3, "t5_restart");
    checkOutput("t5_first_addr", logA[base+2], 32'hB00);
    checkOutput("t5_first_byte", logD[base+2], 8'hCC);
    checkOutput("t5_ovf", overflow, 0);
    checkOutput("t5_dl", downloading, 1);
    waitPulses(base + 6, "t5_pulses");
    step(8);
    pulseDone();
    waitDlLow("t5_dl_fall");

    // Non-contiguous words, completion alongside the second write
    base = logA.size();
    applyStimulus(32'h0, 32'h0A0B0C0D, 1'b0);
    applyStimulus(32'h2000, 32'h1A1B1C1D, 1'b1);
    waitPulses(base + 8, "t6_pulses");
    waitDlLow("t6_dl_fall");
    checkOutput("t6_count", logA.size(), base + 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t6_addr", logA[base+i], addr6[i]);
      checkOutput("t6_byte", logD[base+i], bytes6[i]);
    end
    applyStimulus(32'h3000, 32'hFFEEDDCC, 1'b0);
    checkOutput("t6_dl_restart", downloading, 1);
    waitPulses(base + 12, "t6_restart_pulses");
    step(8);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/jtframe_pocket_dwnld.md
Name: jtframe_pocket_dwnld

Overview:
Download sequencer between the Pocket bridge write port and the core's byte-wide ioctl programming interface. It buffers 32-bit bridge words, already synchronised to the ROM clock, in a small FIFO. Each word is serialised into four byte writes, and each byte waits for the SDRAM loader's prog_rdy acknowledge. The block owns the downloading flag and ends a download only when the bridge reports all data slots complete and every buffered byte has been acknowledged.

Parameters:
DEPTH, 2, log2 of FIFO depth in 32-bit words (default 4 entries)
AW, 25, ioctl address width in bytes

Ports:
clk  in  1  ROM/programming clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
wr  in  1  one-cycle strobe: bridge word valid (already synchronised to clk)
wr_data  in  32  bridge word; byte 0 = wr_data[7:0]
wr_addr  in  32  bridge byte address; only [AW-1:2] used
slot_done  in  1  one-cycle pulse: bridge reports all data slots complete
prog_rdy  in  1  one-cycle pulse: loader accepted the current byte
ioctl_addr  out  AW  byte address of current byte
ioctl_dout  out  8  current byte
ioctl_wr  out  1  one-cycle byte write strobe
downloading  out  1  high from first accepted word until the download completes
overflow  out  1  sticky: a word was dropped because the FIFO was full
fifo_lvl  out  DEPTH+1  words currently held in the FIFO (debug)

Behaviour:
- Reset (rst_n=0 at a clock edge): FIFO emptied; state IDLE; outputs ioctl_addr=0, ioctl_dout=0, ioctl_wr=0, downloading=0, overflow=0, fifo_lvl=0; a pending done flag is cleared. Reset mid-transfer abandons the in-flight word; no further ioctl_wr is issued.
- FIFO entry is {wr_addr[AW-1:2], wr_data}. Push on wr when not full. A push and a pop in the same cycle are both honoured and fifo_lvl is unchanged.
- Full: wr while fifo_lvl == 2^DEPTH drops the word and sets overflow. overflow clears only on reset or on the first accepted wr while downloading=0.
- downloading rises in the cycle after the first accepted wr while it is low.
- States:
  - IDLE: if FIFO not empty, pop one word. Load the shift register. ioctl_addr <= {entry_addr, 2'b00}, ioctl_dout <= data[7:0], ioctl_wr <= 1. Byte counter = 0. Go to WAIT.
  - WAIT: ioctl_wr is low. Wait for prog_rdy; it is ignored in the cycle ioctl_wr is high. On prog_rdy with byte counter < 3: increment the counter and ioctl_addr[1:0], shift data right by 8, issue ioctl_wr for the next byte in the following cycle (stay in WAIT). On prog_rdy with counter == 3: go to IDLE. If the FIFO is not empty, the next word's first ioctl_wr follows 1 cycle later.
- Latency: with the FIFO empty in IDLE, a wr sampled at edge N gives ioctl_wr high in cycle N+2. The byte-to-byte gap is one cycle after prog_rdy.
- ioctl_wr is never high in two consecutive cycles. Exactly 4 pulses are issued per accepted word, in address order +0..+3. Addresses are not required to be contiguous between words; each word reloads the address.
- A prog_rdy pulse while in IDLE, or in the cycle ioctl_wr is high, is ignored.
- slot_done sets the pending done flag; it is ignored if downloading=0. downloading falls, and the pending flag clears, in the cycle after all three hold: the flag is set, the FIFO is empty, and the state is IDLE with no byte outstanding.
- A wr arriving in the same cycle as slot_done is still buffered and sent before downloading falls.
- A new wr after downloading falls starts a new download.
- No timeout: a missing prog_rdy stalls the block indefinitely. The FIFO keeps accepting words until full.

Test Plan:
1. Reset, then wr with wr_addr=0x100, wr_data=0xA1B2C3D4; respond with prog_rdy 3 cycles after each ioctl_wr. Required: ioctl_wr 2 cycles after wr; bytes D4,C3,B2,A1 at ioctl_addr 0x100..0x103; downloading=1 throughout.
2. Five back-to-back wr strobes (DEPTH=2) with prog_rdy withheld. Required: 1 word popped, 4 buffered, fifo_lvl=4. Fifth: if it arrives before the pop, it is dropped and overflow=1; otherwise it is accepted. Check both timings; once prog_rdy resumes, the 16 or 20 bytes emitted are in order.
3. slot_done pulsed while 2 words are still queued. Required: downloading stays 1 until the 8th prog_rdy, then falls 1 cycle after the last handshake completes.
4. prog_rdy asserted in the same cycle as ioctl_wr, and again while IDLE. Required: both ignored; the byte counter does not advance; no extra ioctl_wr.
5. rst_n low for 1 cycle after the 2nd byte of a word. Required: all outputs 0 next cycle, FIFO empty, no further ioctl_wr. A subsequent wr restarts at byte 0 with overflow=0.
6. Two words at addresses 0x0 and 0x2000 (non-contiguous), then slot_done. Required: bytes at 0x0..0x3 and 0x2000..0x2003; downloading falls after the last ack; a later wr raises downloading again.
